// File: rtl/soc_top_v1.sv
// rtl/soc_top_v1.sv - bring-up SoC top: UART boot banner, then echo of received bytes with DTCM log
module soc_top_v1 #(
    parameter int CLK_FREQ     = 10000000,
    parameter int DIV_WID      = 4,
    parameter int HADDR_WIDTH  = 32,
    parameter int PADDR_WIDTH  = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int ITCM_DEEPTH  = 65536,
    parameter int DTCM_DEEPTH  = 65536,
    parameter int PSLV_NUM     = 5,
    parameter int PSLV_LEN     = 16,
    parameter int HSLV_NUM     = 5,
    parameter int HSLV_LEN     = 16,
    parameter int HMAS_NUM     = 5,
    parameter int HMAS_LEN     = 16,
    parameter int HBURST_WIDTH = 3,
    parameter int IRQ_LEN      = 16
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [DIV_WID-1:0] div_factor,
    output logic               uart_txd,
    input  logic               uart_rxd
);

    localparam int AW = $clog2(DTCM_DEEPTH);
    localparam logic [DIV_WID-1:0] CNT_ONE = {{(DIV_WID-1){1'b0}}, 1'b1};

    if (DTCM_DEEPTH != (1 << AW) || DATA_WIDTH < 8 || DIV_WID < 1 || CLK_FREQ < 1 ||
        HADDR_WIDTH < 1 || PADDR_WIDTH < 1 || ITCM_DEEPTH < 1 || PSLV_NUM < 1 ||
        PSLV_LEN < 1 || HSLV_NUM < 1 || HSLV_LEN < 1 || HMAS_NUM < 1 || HMAS_LEN < 1 ||
        HBURST_WIDTH < 1 || IRQ_LEN < 1) begin : g_bad_cfg
        $error("soc_top_v1: invalid parameter set");
    end

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_FRAME} tx_state_t;
    typedef enum logic [2:0] {RX_WAIT, RX_IDLE, RX_START, RX_BITS, RX_DONE} rx_state_t;

    logic [DIV_WID-1:0] n_cur;

    tx_state_t          tx_state, tx_state_nxt;
    logic [DIV_WID-1:0] tx_n, tx_cyc;
    logic [3:0]         tx_bit;
    logic [8:0]         tx_shift;
    logic [3:0]         ban_idx;
    logic               banner_pend, have_byte, tx_bit_end, tx_start;
    logic [7:0]         tx_byte;

    logic [7:0]         fifo_mem [4];
    logic [1:0]         fifo_rd, fifo_wr;
    logic [2:0]         fifo_cnt;
    logic               fifo_full, fifo_push, fifo_pop;
    logic               overrun;

    rx_state_t          rx_state, rx_state_nxt;
    logic               rx_s1, rx_s2;
    logic [DIV_WID-1:0] rx_n, rx_cnt, rx_half;
    logic [3:0]         rx_bit;
    logic [7:0]         rx_shift;
    logic               rx_valid;

    logic [AW-1:0]         wptr;
    logic [DATA_WIDTH-1:0] dtcm [DTCM_DEEPTH];

    function automatic logic [7:0] banner_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    banner_byte = 8'h53;
            3'd1:    banner_byte = 8'h4F;
            3'd2:    banner_byte = 8'h43;
            3'd3:    banner_byte = 8'h20;
            3'd4:    banner_byte = 8'h4F;
            3'd5:    banner_byte = 8'h4B;
            3'd6:    banner_byte = 8'h0D;
            default: banner_byte = 8'h0A;
        endcase
    endfunction

    assign n_cur = (div_factor == '0) ? CNT_ONE : div_factor;

    // Transmitter: banner bytes first, then FIFO echoes; frames chain with no idle gap
    assign banner_pend = (ban_idx != 4'd8);
    assign have_byte   = banner_pend || (fifo_cnt != 3'd0);
    assign tx_bit_end  = (tx_cyc == tx_n - CNT_ONE);
    assign tx_byte     = banner_pend ? banner_byte(ban_idx[2:0]) : fifo_mem[fifo_rd];
    assign fifo_pop    = tx_start && !banner_pend;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_start     = 1'b0;
        case (tx_state)
            TX_IDLE: if (have_byte) tx_state_nxt = TX_LOAD;
            TX_LOAD: begin
                tx_start     = 1'b1;
                tx_state_nxt = TX_FRAME;
            end
            TX_FRAME: begin
                if (tx_bit_end && tx_bit == 4'd9) begin
                    if (have_byte) tx_start = 1'b1;
                    else           tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) tx_state <= TX_IDLE;
        else          tx_state <= tx_state_nxt;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            uart_txd <= 1'b1;
            ban_idx  <= 4'd0;
            tx_n     <= CNT_ONE;
            tx_cyc   <= '0;
            tx_bit   <= 4'd0;
            tx_shift <= '1;
        end else if (tx_start) begin
            uart_txd <= 1'b0;
            tx_shift <= {1'b1, tx_byte};
            tx_bit   <= 4'd0;
            tx_cyc   <= '0;
            tx_n     <= n_cur;
            if (banner_pend) ban_idx <= ban_idx + 4'd1;
        end else if (tx_state == TX_FRAME) begin
            if (tx_bit_end) begin
                tx_cyc <= '0;
                if (tx_bit != 4'd9) begin
                    uart_txd <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 4'd1;
                end
            end else begin
                tx_cyc <= tx_cyc + CNT_ONE;
            end
        end
    end

    // Echo FIFO; a full FIFO still accepts a push when the same cycle pops
    assign fifo_full = (fifo_cnt == 3'd4);
    assign fifo_push = rx_valid && (!fifo_full || fifo_pop);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            fifo_rd  <= 2'd0;
            fifo_wr  <= 2'd0;
            fifo_cnt <= 3'd0;
            overrun  <= 1'b0;
        end else begin
            if (fifo_push) fifo_wr <= fifo_wr + 2'd1;
            if (fifo_pop)  fifo_rd <= fifo_rd + 2'd1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (rx_valid && !fifo_push) overrun <= 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (fifo_push) fifo_mem[fifo_wr] <= rx_shift;
    end

    // Receiver: start re-checked at mid start bit, then one sample per bit period
    assign rx_half  = rx_n >> 1;
    assign rx_valid = (rx_state == RX_DONE);

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_WAIT:  if (rx_s2)  rx_state_nxt = RX_IDLE;
            RX_IDLE:  if (!rx_s2) rx_state_nxt = RX_START;
            RX_START: if (rx_cnt >= rx_half) rx_state_nxt = rx_s2 ? RX_IDLE : RX_BITS;
            RX_BITS: begin
                if (rx_cnt == rx_n && rx_bit == 4'd8) rx_state_nxt = rx_s2 ? RX_DONE : RX_WAIT;
            end
            RX_DONE:  rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_WAIT;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) rx_state <= RX_WAIT;
        else          rx_state <= rx_state_nxt;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_n     <= CNT_ONE;
            rx_cnt   <= CNT_ONE;
            rx_bit   <= 4'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1 <= uart_rxd;
            rx_s2 <= rx_s1;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_n   <= n_cur;
                        rx_cnt <= CNT_ONE;
                    end
                end
                RX_START: begin
                    if (rx_cnt >= rx_half) begin
                        rx_cnt <= CNT_ONE;
                        rx_bit <= 4'd0;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_BITS: begin
                    if (rx_cnt == rx_n) begin
                        rx_cnt <= CNT_ONE;
                        rx_bit <= rx_bit + 4'd1;
                        if (rx_bit != 4'd8) rx_shift <= {rx_s2, rx_shift[7:1]};
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)      wptr <= '0;
        else if (rx_valid) wptr <= wptr + {{(AW-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge hclk) begin
        if (rx_valid) dtcm[wptr] <= DATA_WIDTH'(rx_shift);
    end

endmodule

// File: tb/tb_soc_top_v1.sv
// tb/tb_soc_top_v1.sv - directed self-checking bench for soc_top_v1
module tb_soc_top_v1;

    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic [3:0] div_factor = 4'd10;
    logic       uart_txd;
    logic       uart_rxd = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = 0;

    logic [7:0] banner [8] = '{8'h53, 8'h4F, 8'h43, 8'h20, 8'h4F, 8'h4B, 8'h0D, 8'h0A};

    soc_top_v1 dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .div_factor (div_factor),
        .uart_txd   (uart_txd),
        .uart_rxd   (uart_rxd)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    task automatic do_reset(input logic rxd_val, input logic [3:0] div, output int r);
        hresetn    = 1'b0;
        uart_rxd   = rxd_val;
        div_factor = div;
        repeat (5) @(negedge hclk);
        hresetn = 1'b1;
        r = cyc;
    endtask

    task automatic get_tx(input int n, input int limit, output logic [7:0] b, output int t0);
        int w;
        w  = 0;
        b  = 8'hxx;
        t0 = -1;
        while (uart_txd !== 1'b0 && w < limit) begin
            @(negedge hclk);
            w++;
        end
        if (uart_txd !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL tx_start_timeout waited %0d cycles, required start within %0d", w, limit);
            return;
        end
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (n) @(negedge hclk);
            b[i] = uart_txd;
        end
        repeat (n) @(negedge hclk);
        checks++;
        if (uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL tx_stop_bit got %b expected 1", uart_txd);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int n);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (n) @(negedge hclk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic check_quiet(input int ncyc, input string name);
        int zeros;
        zeros = 0;
        repeat (ncyc) begin
            @(negedge hclk);
            if (uart_txd !== 1'b1) zeros++;
        end
        checks++;
        if (zeros != 0) begin
            errors++;
            $display("FAIL %s txd low for %0d cycles expected 0", name, zeros);
        end
    endtask

    task automatic test_reset;
        @(negedge hclk);
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b expected 1", uart_txd); end
        checks++;
        if (dut.wptr !== '0) begin errors++; $display("FAIL reset_wptr got %0d expected 0", dut.wptr); end
        checks++;
        if (dut.fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_fifo_cnt got %0d expected 0", dut.fifo_cnt); end
        checks++;
        if (dut.ban_idx !== 4'd0) begin errors++; $display("FAIL reset_ban_idx got %0d expected 0", dut.ban_idx); end
        checks++;
        if (dut.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", dut.overrun); end
        repeat (19) @(negedge hclk);
        hresetn = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_banner;
        logic [7:0] b;
        int t;
        for (int i = 0; i < 8; i++) begin
            get_tx(10, 150, b, t);
            checks++;
            if (b !== banner[i]) begin errors++; $display("FAIL banner_byte%0d got %h expected %h", i, b, banner[i]); end
            checks++;
            if (t != rel_cyc + 2 + 100 * i) begin
                errors++;
                $display("FAIL banner_start%0d got cycle %0d expected %0d", i, t, rel_cyc + 2 + 100 * i);
            end
        end
        check_quiet(300, "banner_idle");
        checks++;
        if (dut.wptr !== '0) begin errors++; $display("FAIL rx_low_wptr got %0d expected 0", dut.wptr); end
    endtask

    task automatic test_echo;
        logic [7:0] b;
        int t, r;
        do_reset(1'b1, 4'd10, r);
        for (int i = 0; i < 8; i++) get_tx(10, 150, b, t);
        fork
            send_rx(8'hA5, 1'b1, 10);
            get_tx(10, 300, b, t);
        join
        checks++;
        if (b !== 8'hA5) begin errors++; $display("FAIL echo_byte got %h expected a5", b); end
        checks++;
        if (dut.dtcm[0] !== 32'h000000A5) begin errors++; $display("FAIL echo_dtcm0 got %h expected 000000a5", dut.dtcm[0]); end
        checks++;
        if (dut.wptr !== 16'd1) begin errors++; $display("FAIL echo_wptr got %0d expected 1", dut.wptr); end
    endtask

    task automatic test_during_banner;
        logic [7:0] b;
        int t, r;
        do_reset(1'b1, 4'd10, r);
        fork
            begin
                repeat (100) @(negedge hclk);
                send_rx(8'h31, 1'b1, 10);
            end
            for (int i = 0; i < 9; i++) get_tx(10, 150, b, t);
        join
        checks++;
        if (b !== 8'h31) begin errors++; $display("FAIL queued_echo_byte got %h expected 31", b); end
        checks++;
        if (t != r + 802) begin errors++; $display("FAIL queued_echo_start got cycle %0d expected %0d", t, r + 802); end
    endtask

    task automatic test_overrun;
        logic [7:0] bs [12];
        int ts [12];
        int r;
        do_reset(1'b1, 4'd10, r);
        fork
            begin
                repeat (10) @(negedge hclk);
                for (int k = 1; k <= 6; k++) send_rx(8'(k), 1'b1, 10);
            end
            for (int i = 0; i < 12; i++) get_tx(10, 150, bs[i], ts[i]);
        join
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bs[8+i] !== 8'(i + 1) || ts[8+i] != r + 802 + 100 * i) begin
                errors++;
                $display("FAIL overrun_echo%0d got %h@%0d expected %h@%0d", i, bs[8+i], ts[8+i], i + 1, r + 802 + 100 * i);
            end
        end
        check_quiet(300, "overrun_no_extra_echo");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dut.dtcm[i] !== 32'(i + 1)) begin errors++; $display("FAIL overrun_dtcm%0d got %h expected %h", i, dut.dtcm[i], i + 1); end
        end
        checks++;
        if (dut.wptr !== 16'd6) begin errors++; $display("FAIL overrun_wptr got %0d expected 6", dut.wptr); end
        checks++;
        if (dut.overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b expected 1", dut.overrun); end
    endtask

    task automatic test_framing;
        logic [7:0] b;
        int t, r;
        do_reset(1'b1, 4'd10, r);
        fork
            begin
                repeat (10) @(negedge hclk);
                send_rx(8'h77, 1'b0, 10);
                repeat (20) @(negedge hclk);
                send_rx(8'h5A, 1'b1, 10);
            end
            for (int i = 0; i < 9; i++) get_tx(10, 150, b, t);
        join
        checks++;
        if (b !== 8'h5A || t != r + 802) begin
            errors++;
            $display("FAIL framing_echo got %h@%0d expected 5a@%0d", b, t, r + 802);
        end
        check_quiet(300, "framing_no_extra_echo");
        checks++;
        if (dut.dtcm[0] !== 32'h0000005A) begin errors++; $display("FAIL framing_dtcm0 got %h expected 0000005a", dut.dtcm[0]); end
        checks++;
        if (dut.wptr !== 16'd1) begin errors++; $display("FAIL framing_wptr got %0d expected 1", dut.wptr); end
        checks++;
        if (dut.overrun !== 1'b0) begin errors++; $display("FAIL framing_overrun got %b expected 0", dut.overrun); end
    endtask

    task automatic test_div0;
        logic [7:0] b;
        int t, r;
        do_reset(1'b1, 4'd0, r);
        for (int i = 0; i < 3; i++) begin
            get_tx(1, 20, b, t);
            checks++;
            if (b !== banner[i] || t != r + 2 + 10 * i) begin
                errors++;
                $display("FAIL div0_byte%0d got %h@%0d expected %h@%0d", i, b, t, banner[i], r + 2 + 10 * i);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        int t, r, w;
        do_reset(1'b1, 4'd10, r);
        repeat (250) @(negedge hclk);
        w = 0;
        while (uart_txd !== 1'b0 && w < 50) begin
            @(negedge hclk);
            w++;
        end
        hresetn = 1'b0;
        #1;
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL midreset_txd got %b expected 1", uart_txd); end
        checks++;
        if (dut.ban_idx !== 4'd0) begin errors++; $display("FAIL midreset_ban_idx got %0d expected 0", dut.ban_idx); end
        repeat (4) @(negedge hclk);
        hresetn = 1'b1;
        r = cyc;
        get_tx(10, 20, b, t);
        checks++;
        if (b !== 8'h53 || t != r + 2) begin
            errors++;
            $display("FAIL midreset_restart got %h@%0d expected 53@%0d", b, t, r + 2);
        end
    endtask

    initial begin
        test_reset;
        test_banner;
        test_echo;
        test_during_banner;
        test_overrun;
        test_framing;
        test_div0;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
